madgwick_sched: RTL and testbench

- Sample-rate sequencer for the madgwick filter core inside the attitude_sensor peripheral.
- Generates a fixed-period update tick that matches the core's delta_t, and latches the newest IMU sample from the sensor reader.
- Issues one core transaction per tick over the core's valid_in/ready_in and valid_out/ready_out handshakes.
- Registers the resulting normalised quaternion for the bus side and reports overrun, missed-sample and timeout status.

---
 rtl/madgwick_sched.sv | 170 +++++++++++++++++
 tb/tb_madgwick_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/madgwick_sched.sv
// madgwick_sched: fixed-rate sequencer feeding latched IMU samples to the madgwick core and registering its quaternion
module madgwick_sched #(
    parameter int ACC_W          = 16,
    parameter int GYRO_W         = 16,
    parameter int Q_W            = 16,
    parameter int Q_FRAC         = 14,
    parameter int PERIOD_CYCLES  = 100000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clr_status,
    input  logic              sample_valid,
    input  logic [ACC_W-1:0]  a_x,
    input  logic [ACC_W-1:0]  a_y,
    input  logic [ACC_W-1:0]  a_z,
    input  logic [GYRO_W-1:0] w_x,
    input  logic [GYRO_W-1:0] w_y,
    input  logic [GYRO_W-1:0] w_z,
    output logic              core_rst_n,
    output logic              core_valid_in,
    input  logic              core_ready_in,
    output logic [ACC_W-1:0]  core_a_x,
    output logic [ACC_W-1:0]  core_a_y,
    output logic [ACC_W-1:0]  core_a_z,
    output logic [GYRO_W-1:0] core_w_x,
    output logic [GYRO_W-1:0] core_w_y,
    output logic [GYRO_W-1:0] core_w_z,
    input  logic              core_valid_out,
    output logic              core_ready_out,
    input  logic [Q_W-1:0]    core_q_w,
    input  logic [Q_W-1:0]    core_q_x,
    input  logic [Q_W-1:0]    core_q_y,
    input  logic [Q_W-1:0]    core_q_z,
    output logic [Q_W-1:0]    q_w,
    output logic [Q_W-1:0]    q_x,
    output logic [Q_W-1:0]    q_y,
    output logic [Q_W-1:0]    q_z,
    output logic              q_valid,
    output logic              busy,
    output logic [15:0]       overrun_cnt,
    output logic [15:0]       miss_cnt,
    output logic              err_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, RECOVER} state_t;
    localparam int SW = 3 * ACC_W + 3 * GYRO_W;
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [Q_W-1:0] Q_ONE = Q_W'(1) << Q_FRAC;
    localparam logic [PW-1:0] TICK_AT = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TO_AT = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [PW-1:0] tick_cnt;
    logic [TW-1:0] to_cnt;
    logic [SW-1:0] sample, hold, shadow;
    logic          tick, timed_out, have_sample, shadow_valid, rec_cnt, cap;

    assign sample = {a_x, a_y, a_z, w_x, w_y, w_z};
    assign {core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z} = hold;
    assign tick = enable && tick_cnt == TICK_AT;
    assign timed_out = to_cnt == TO_AT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else
            tick_cnt <= (!enable || tick) ? '0 : tick_cnt + 1'b1;
    end

    // While a sample is being offered the holding register stays frozen; newer data waits in the shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold         <= '0;
            shadow       <= '0;
            have_sample  <= 1'b0;
            shadow_valid <= 1'b0;
        end else if (state == ISSUE) begin
            if (sample_valid) begin
                shadow       <= sample;
                shadow_valid <= 1'b1;
            end
            if (core_ready_in && !sample_valid && !shadow_valid)
                have_sample <= 1'b0;
        end else if (sample_valid) begin
            hold         <= sample;
            have_sample  <= 1'b1;
            shadow_valid <= 1'b0;
        end else if (shadow_valid) begin
            hold         <= shadow;
            shadow_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            core_valid_in  <= 1'b0;
            core_ready_out <= 1'b0;
            core_rst_n     <= 1'b1;
            busy           <= 1'b0;
            to_cnt         <= '0;
            rec_cnt        <= 1'b0;
            cap            <= 1'b0;
            q_valid        <= 1'b0;
            err_timeout    <= 1'b0;
            overrun_cnt    <= '0;
            miss_cnt       <= '0;
            q_w            <= Q_ONE;
            q_x            <= '0;
            q_y            <= '0;
            q_z            <= '0;
        end else begin
            cap     <= 1'b0;
            q_valid <= cap;
            to_cnt  <= to_cnt + 1'b1;
            case (state)
                IDLE: if (tick && have_sample) begin
                    state         <= ISSUE;
                    core_valid_in <= 1'b1;
                    busy          <= 1'b1;
                    to_cnt        <= '0;
                end
                ISSUE: if (core_ready_in) begin
                    state          <= WAIT_RESULT;
                    core_valid_in  <= 1'b0;
                    core_ready_out <= 1'b1;
                end else if (timed_out) begin
                    state         <= RECOVER;
                    core_valid_in <= 1'b0;
                    core_rst_n    <= 1'b0;
                    err_timeout   <= 1'b1;
                end
                WAIT_RESULT: if (core_valid_out) begin
                    state          <= IDLE;
                    core_ready_out <= 1'b0;
                    busy           <= 1'b0;
                    cap            <= 1'b1;
                    q_w            <= core_q_w;
                    q_x            <= core_q_x;
                    q_y            <= core_q_y;
                    q_z            <= core_q_z;
                end else if (timed_out) begin
                    state          <= RECOVER;
                    core_ready_out <= 1'b0;
                    core_rst_n     <= 1'b0;
                    err_timeout    <= 1'b1;
                end
                default: begin
                    rec_cnt <= ~rec_cnt;
                    if (rec_cnt) begin
                        state      <= IDLE;
                        core_rst_n <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
            endcase
            if (tick && state != IDLE && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 1'b1;
            if (tick && state == IDLE && !have_sample && miss_cnt != '1)
                miss_cnt <= miss_cnt + 1'b1;
            if (clr_status) begin
                overrun_cnt <= '0;
                miss_cnt    <= '0;
                err_timeout <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_madgwick_sched.sv
// tb_madgwick_sched: scenario tasks against a behavioural core model and tick arithmetic
module tb_madgwick_sched;
    localparam logic [15:0] ONE = 16'd16384;
    logic clk = 0, rst = 1, enable = 0, clr_status = 0, sample_valid = 0;
    logic [15:0] a_x = 0, a_y = 0, a_z = 0, w_x = 0, w_y = 0, w_z = 0;
    logic core_rst_n, core_valid_in, core_ready_in = 0, core_valid_out = 0, core_ready_out;
    logic [15:0] core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z;
    logic [15:0] core_q_w = 0, core_q_x = 0, core_q_y = 0, core_q_z = 0;
    logic [15:0] q_w, q_x, q_y, q_z, overrun_cnt, miss_cnt;
    logic q_valid, busy, err_timeout;
    int total = 0, bad = 0, cyc = 0, base = 0;
    int stall_cycles = 0, resp_cycles = 0, stall_left = 0, resp_left = 0, n_issue = 0, vo_cyc = -10;
    bit resp_en = 0;
    logic [95:0] got[$];
    logic [63:0] next_q = 0;

    madgwick_sched #(.ACC_W(16), .GYRO_W(16), .Q_W(16), .Q_FRAC(14), .PERIOD_CYCLES(20), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status), .sample_valid(sample_valid),
        .a_x(a_x), .a_y(a_y), .a_z(a_z), .w_x(w_x), .w_y(w_y), .w_z(w_z),
        .core_rst_n(core_rst_n), .core_valid_in(core_valid_in), .core_ready_in(core_ready_in),
        .core_a_x(core_a_x), .core_a_y(core_a_y), .core_a_z(core_a_z),
        .core_w_x(core_w_x), .core_w_y(core_w_y), .core_w_z(core_w_z),
        .core_valid_out(core_valid_out), .core_ready_out(core_ready_out),
        .core_q_w(core_q_w), .core_q_x(core_q_x), .core_q_y(core_q_y), .core_q_z(core_q_z),
        .q_w(q_w), .q_x(q_x), .q_y(q_y), .q_z(q_z), .q_valid(q_valid), .busy(busy),
        .overrun_cnt(overrun_cnt), .miss_cnt(miss_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: accepts after stall_cycles, answers resp_cycles later with next_q
    always @(negedge clk) begin
        core_ready_in = 0;
        core_valid_out = 0;
        if (rst) begin
            stall_left = stall_cycles;
            resp_left = resp_cycles;
        end else begin
            if (core_valid_in) begin
                if (stall_left == 0) begin
                    core_ready_in = 1;
                    got.push_back({core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z});
                    n_issue++;
                end else stall_left--;
            end else stall_left = stall_cycles;
            if (core_ready_out && resp_en) begin
                if (resp_left == 0) begin
                    core_valid_out = 1;
                    {core_q_w, core_q_x, core_q_y, core_q_z} = next_q;
                    vo_cyc = cyc + 1;
                end else resp_left--;
            end else resp_left = resp_cycles;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int e);
        while (cyc - base < e) step();
    endtask

    task automatic do_reset(input int st, input int rs, input bit re);
        rst = 1; enable = 0; clr_status = 0; sample_valid = 0;
        stall_cycles = st; resp_cycles = rs; resp_en = re;
        got.delete(); n_issue = 0; vo_cyc = -10;
        step(); step();
        enable = 1; rst = 0; base = cyc;
    endtask

    task automatic send(input logic [95:0] s);
        {a_x, a_y, a_z, w_x, w_y, w_z} = s;
        sample_valid = 1;
        step();
        sample_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; step(); step();
        total++; if ({q_w, q_x, q_y, q_z} !== {ONE, 48'd0}) begin bad++; $display("FAIL reset_q got=%0h want=%0h", {q_w, q_x, q_y, q_z}, {ONE, 48'd0}); end
        total++; if (core_rst_n !== 1'b1) begin bad++; $display("FAIL reset_core_rst_n got=%b want=1", core_rst_n); end
        total++; if ({overrun_cnt, miss_cnt} !== 32'd0) begin bad++; $display("FAIL reset_counters got=%0h want=0", {overrun_cnt, miss_cnt}); end
        total++; if ({err_timeout, q_valid, busy, core_valid_in, core_ready_out} !== 5'd0) begin bad++; $display("FAIL reset_flags got=%b want=0", {err_timeout, q_valid, busy, core_valid_in, core_ready_out}); end
    endtask

    task automatic test_transaction();
        logic [95:0] s; logic [63:0] qexp; int qv_n, qv_at;
        qv_n = 0; qv_at = -1;
        do_reset(0, 50, 1);
        next_q = {$urandom, $urandom}; qexp = next_q;
        s = {$urandom, $urandom, $urandom}; s[63:48] = 16'd16384;
        wait_to($urandom_range(2, 14)); send(s);
        while (cyc - base < 199) begin
            step();
            if (q_valid) begin
                qv_n++; qv_at = cyc;
                total++; if ({q_w, q_x, q_y, q_z} !== qexp) begin bad++; $display("FAIL txn_q got=%0h want=%0h", {q_w, q_x, q_y, q_z}, qexp); end
            end
            if (cyc - base == 19) begin total++; if (core_valid_in !== 1'b0) begin bad++; $display("FAIL txn_pre_tick_valid got=%b want=0", core_valid_in); end end
            if (cyc - base == 20) begin total++; if (core_valid_in !== 1'b1) begin bad++; $display("FAIL txn_tick_valid got=%b want=1", core_valid_in); end end
        end
        total++; if (qv_n != 1) begin bad++; $display("FAIL txn_qvalid_count got=%0d want=1", qv_n); end
        total++; if (qv_at != vo_cyc + 1) begin bad++; $display("FAIL txn_qvalid_time got=%0d want=%0d", qv_at, vo_cyc + 1); end
        total++; if (n_issue != 1 || got[0] !== s) begin bad++; $display("FAIL txn_issue got=%0d/%0h want=1/%0h", n_issue, got[0], s); end
        total++; if (overrun_cnt !== 16'd2) begin bad++; $display("FAIL txn_overrun got=%0d want=2", overrun_cnt); end
        total++; if (miss_cnt !== 16'd6) begin bad++; $display("FAIL txn_miss got=%0d want=6", miss_cnt); end
        clr_status = 1; step(); clr_status = 0;
        total++; if ({overrun_cnt, miss_cnt} !== 32'd0) begin bad++; $display("FAIL txn_clr_vs_tick got=%0h want=0", {overrun_cnt, miss_cnt}); end
    endtask

    task automatic test_stall();
        logic [95:0] s1, s2;
        do_reset(3, 5, 1);
        s1 = {$urandom, $urandom, $urandom}; s2 = ~s1;
        wait_to(4); send(s1);
        wait_to(20);
        total++; if ({core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z} !== s1) begin bad++; $display("FAIL stall_data20 got=%0h want=%0h", {core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z}, s1); end
        step(); send(s2);
        total++; if ({core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z} !== s1) begin bad++; $display("FAIL stall_data22 got=%0h want=%0h", {core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z}, s1); end
        step();
        total++; if (core_valid_in !== 1'b1 || {core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z} !== s1) begin bad++; $display("FAIL stall_data23 got=%b/%0h want=1/%0h", core_valid_in, {core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z}, s1); end
        step();
        total++; if (core_valid_in !== 1'b0) begin bad++; $display("FAIL stall_accept got=%b want=0", core_valid_in); end
        wait_to(50);
        total++; if (got.size() != 2 || got[0] !== s1 || got[1] !== s2) begin bad++; $display("FAIL stall_issued got=%0d/%0h/%0h want=2/%0h/%0h", got.size(), got[0], got[1], s1, s2); end
        total++; if ({overrun_cnt, miss_cnt} !== 32'd0) begin bad++; $display("FAIL stall_counters got=%0h want=0", {overrun_cnt, miss_cnt}); end
    endtask

    task automatic test_timeout();
        do_reset(0, 0, 0);
        wait_to(4); send({$urandom, $urandom, $urandom});
        wait_to(83);
        total++; if (err_timeout !== 1'b0 || core_rst_n !== 1'b1) begin bad++; $display("FAIL to_early got=%b%b want=01", err_timeout, core_rst_n); end
        step();
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", err_timeout); end
        total++; if ({core_rst_n, core_ready_out, core_valid_in, busy} !== 4'b0001) begin bad++; $display("FAIL to_recover got=%b want=0001", {core_rst_n, core_ready_out, core_valid_in, busy}); end
        step();
        total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL to_rst_n_2nd got=%b want=0", core_rst_n); end
        step();
        total++; if (core_rst_n !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL to_release got=%b%b want=10", core_rst_n, busy); end
        total++; if (overrun_cnt !== 16'd3) begin bad++; $display("FAIL to_overrun got=%0d want=3", overrun_cnt); end
        total++; if ({q_w, q_x, q_y, q_z} !== {ONE, 48'd0} || q_valid !== 1'b0) begin bad++; $display("FAIL to_q_kept got=%0h want=%0h", {q_w, q_x, q_y, q_z}, {ONE, 48'd0}); end
        wait_to(90); send({$urandom, $urandom, $urandom});
        wait_to(99);
        total++; if (core_valid_in !== 1'b0) begin bad++; $display("FAIL to_reissue_pre got=%b want=0", core_valid_in); end
        step();
        total++; if (core_valid_in !== 1'b1) begin bad++; $display("FAIL to_reissue got=%b want=1", core_valid_in); end
        clr_status = 1; step(); clr_status = 0;
        total++; if (err_timeout !== 1'b0 || overrun_cnt !== 16'd0) begin bad++; $display("FAIL to_clr got=%b/%0d want=0/0", err_timeout, overrun_cnt); end
    endtask

    task automatic test_enable_drop();
        logic [63:0] qexp; int qv_n, qv_at;
        qv_n = 0; qv_at = -1;
        do_reset(0, 30, 1);
        next_q = {$urandom, $urandom}; qexp = next_q;
        wait_to(4); send({$urandom, $urandom, $urandom});
        wait_to(30); enable = 0;
        while (cyc - base < 70) begin
            step();
            if (q_valid) begin
                qv_n++; qv_at = cyc;
                total++; if ({q_w, q_x, q_y, q_z} !== qexp) begin bad++; $display("FAIL en_q got=%0h want=%0h", {q_w, q_x, q_y, q_z}, qexp); end
            end
        end
        total++; if (qv_n != 1 || qv_at != vo_cyc + 1) begin bad++; $display("FAIL en_qvalid got=%0d@%0d want=1@%0d", qv_n, qv_at, vo_cyc + 1); end
        total++; if (n_issue != 1 || {overrun_cnt, miss_cnt} !== 32'd0) begin bad++; $display("FAIL en_no_ticks got=%0d/%0h want=1/0", n_issue, {overrun_cnt, miss_cnt}); end
        enable = 1;
        wait_to(89);
        total++; if (miss_cnt !== 16'd0) begin bad++; $display("FAIL en_restart_early got=%0d want=0", miss_cnt); end
        step();
        total++; if (miss_cnt !== 16'd1) begin bad++; $display("FAIL en_restart_tick got=%0d want=1", miss_cnt); end
    endtask

    task automatic test_reset_in_wait();
        logic [63:0] qexp;
        do_reset(0, 10, 1);
        next_q = {$urandom, $urandom} | 64'h0001_0001_0001_0001; qexp = next_q;
        wait_to(4); send({$urandom, $urandom, $urandom});
        wait_to(34);
        total++; if ({q_w, q_x, q_y, q_z} !== qexp) begin bad++; $display("FAIL rw_first_q got=%0h want=%0h", {q_w, q_x, q_y, q_z}, qexp); end
        send({$urandom, $urandom, $urandom});
        wait_to(45);
        total++; if (core_ready_out !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rw_in_wait got=%b%b want=11", core_ready_out, busy); end
        rst = 1; #1;
        total++; if ({core_valid_in, core_ready_out, busy, q_valid} !== 4'd0) begin bad++; $display("FAIL rw_async_flags got=%b want=0000", {core_valid_in, core_ready_out, busy, q_valid}); end
        total++; if ({q_w, q_x, q_y, q_z} !== {ONE, 48'd0}) begin bad++; $display("FAIL rw_identity got=%0h want=%0h", {q_w, q_x, q_y, q_z}, {ONE, 48'd0}); end
    endtask

    initial begin
        test_reset();
        test_transaction();
        test_stall();
        test_timeout();
        test_enable_drop();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
